// File: rtl/serial_frame_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_pkg
// Shared types and constants for the framed serial receiver.
//   rx_state_e       : receiver FSM states
//   MIN_DATA_W       : smallest legal data width
//   MIN_CLKS_PER_BIT : smallest legal bit period (needs a distinct mid-bit point)
//   half_bit()       : mid-bit offset, in clk cycles, for a given bit period
// -----------------------------------------------------------------------------
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_e;

   localparam int MIN_DATA_W       = 1;
   localparam int MIN_CLKS_PER_BIT = 2;

   function automatic int half_bit(input int clks_per_bit);
      return clks_per_bit / 2;
   endfunction

endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to 1
// so an idle-high line does not look like a start bit coming out of reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
// Receives idle-high serial frames (start 0, DATA_W data bits LSB first,
// optional even parity bit, stop 1) and presents each word on a parallel bus.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN adds the parity bit,
// the PARITY state and the parity_err port.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data_input : serial line, asynchronous, idle high
//   data_out   : last received word, held until the next frame completes
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : with data_valid, stop bit was sampled 0
//   parity_err : with data_valid, even parity failed (macro only)
//   busy       : receiver is not in IDLE
// -----------------------------------------------------------------------------
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_input,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
`ifdef SERIAL_FRAME_RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   // Bit period is held at its legal minimum so mid-bit sampling stays defined.
   localparam int CPB   = (CLKS_PER_BIT > MIN_CLKS_PER_BIT) ? CLKS_PER_BIT : MIN_CLKS_PER_BIT;
   localparam int HALF  = half_bit(CPB);
   localparam int CNT_W = $clog2(CPB);
   localparam int IDX_W = $clog2(((DATA_W > MIN_DATA_W) ? DATA_W : MIN_DATA_W) + 1);

   logic din_s;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (data_input),
      .q_o   (din_s)
   );

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] dout_q,  dout_d;
   logic              valid_q, valid_d;
   logic              ferr_q,  ferr_d;
   logic              busy_q,  busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic              par_q,   par_d;
   logic              perr_q,  perr_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!din_s) begin
               state_d = START;
               cnt_d   = CNT_W'(HALF - 1);
            end
         end
         // Re-check the line at mid start bit to reject glitches.
         START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!din_s) begin
               state_d = DATA;
               cnt_d   = CNT_W'(CPB - 1);
               idx_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         // Shift in at the MSB and move right: first bit lands in bit 0.
         DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shift_d = (shift_q >> 1) | (DATA_W'(din_s) << (DATA_W - 1));
               cnt_d   = CNT_W'(CPB - 1);
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef SERIAL_FRAME_RX_PARITY_EN
         PARITY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               par_d   = din_s;
               cnt_d   = CNT_W'(CPB - 1);
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               dout_d  = shift_q;
               valid_d = 1'b1;
               ferr_d  = !din_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
               perr_d  = (^shift_q) ^ par_q;
`endif
               state_d = din_s ? IDLE : BREAK;
            end
         end
         // A line held low after a bad stop bit must go high before a new start.
         BREAK: begin
            if (din_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign busy       = busy_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
// Self-checking bench for serial_frame_rx (DATA_W=8, CLKS_PER_BIT=4).
// Frames are driven bit-serially; every data_valid pulse is logged with its
// cycle number and compared with times/values computed from the frame format.
// Honors SERIAL_FRAME_RX_PARITY_EN for the parity port and frame length.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int DW   = 8;
   localparam int CPB  = 4;
   localparam int HALF = CPB / 2;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          data_input = 1'b1;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          frame_err;
   logic          parity_err;
   logic          busy;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int qual_viol = 0;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } rec_t;

   rec_t got_q[$];
   rec_t exp_q[$];
   logic busy_log [0:8191];

   serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_input (data_input),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
`ifdef SERIAL_FRAME_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

`ifndef SERIAL_FRAME_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sampled on the falling edge, cyc = number of the last rising edge.
   always @(negedge clk) begin
      if (data_valid) got_q.push_back('{cyc, data_out, frame_err, parity_err});
      if (!data_valid && (frame_err || parity_err)) qual_viol <= qual_viol + 1;
      if (cyc < 8192) busy_log[cyc] <= busy;
   end

   // Start bit captured at e0; valid rises after mid-start + data (+parity) + stop.
   function automatic int vcyc(input int e0);
      return e0 + 2 + HALF + (DW + 1 + PB) * CPB;
   endfunction

   function automatic logic eperr(input logic [7:0] d, input logic p);
      return (PB != 0) ? ((^d) ^ p) : 1'b0;
   endfunction

   // Drive one frame; the stop bit is left on the line for the caller.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                             output int e0);
      @(negedge clk);
      data_input = 1'b0;
      e0 = cyc + 1;
      for (int i = 0; i < DW; i++) begin
         repeat (CPB) @(negedge clk);
         data_input = d[i];
      end
      if (PB != 0) begin
         repeat (CPB) @(negedge clk);
         data_input = pbit;
      end
      repeat (CPB) @(negedge clk);
      data_input = stop;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      data_input = 1'b1;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      data_input = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_out, data_valid, frame_err, parity_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_state: got dout=%h vld=%b ferr=%b perr=%b busy=%b, expected all 0",
                  data_out, data_valid, frame_err, parity_err, busy);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b vld=%b, expected 0 0", busy, data_valid);
      end
   endtask

   task automatic test_a5();
      int e0;
      got_q.delete(); exp_q.delete();
      send_frame(8'hA5, 1'b1, 1'b0, e0);
      idle(20);
      exp_q.push_back('{vcyc(e0), 8'hA5, 1'b0, eperr(8'hA5, 1'b0)});
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL a5_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL a5_pulse: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
      checks++;
      if (busy_log[vcyc(e0) - 1] !== 1'b1 || busy_log[vcyc(e0) + 1] !== 1'b0) begin
         errors++;
         $display("FAIL a5_busy: got before=%b after=%b, expected 1 0",
                  busy_log[vcyc(e0) - 1], busy_log[vcyc(e0) + 1]);
      end
      checks++;
      if (data_out !== 8'hA5) begin
         errors++;
         $display("FAIL a5_hold: got data_out=%h, expected a5", data_out);
      end
   endtask

   task automatic test_false_start();
      int e0;
      got_q.delete();
      @(negedge clk);
      data_input = 1'b0;
      e0 = cyc + 1;
      idle(20);
      checks++;
      if (got_q.size() !== 0) begin
         errors++;
         $display("FAIL false_start_pulse: got %0d pulses, expected 0", got_q.size());
      end
      checks++;
      if (busy_log[e0 + 1] !== 1'b0 || busy_log[e0 + 2] !== 1'b1 ||
          busy_log[e0 + 2 + HALF] !== 1'b0) begin
         errors++;
         $display("FAIL false_start_busy: got %b%b%b, expected 010",
                  busy_log[e0 + 1], busy_log[e0 + 2], busy_log[e0 + 2 + HALF]);
      end
   endtask

   task automatic test_break();
      int e0;
      got_q.delete(); exp_q.delete();
      send_frame(8'h3C, 1'b0, 1'b0, e0);
      repeat (40) @(negedge clk);
      exp_q.push_back('{vcyc(e0), 8'h3C, 1'b1, eperr(8'h3C, 1'b0)});
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL break_busy: got busy=%b while line low, expected 1", busy);
      end
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size() || busy !== 1'b0) begin
         errors++;
         $display("FAIL break_count: got %0d pulses busy=%b, expected %0d busy=0",
                  got_q.size(), busy, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL break_pulse: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
   endtask

   task automatic test_back_to_back();
      int e0, e1;
      got_q.delete(); exp_q.delete();
      send_frame(8'h00, 1'b1, 1'b0, e0);
      send_frame(8'hFF, 1'b1, 1'b0, e1);
      idle(20);
      exp_q.push_back('{vcyc(e0), 8'h00, 1'b0, eperr(8'h00, 1'b0)});
      exp_q.push_back('{vcyc(e1), 8'hFF, 1'b0, eperr(8'hFF, 1'b0)});
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL b2b_pulse%0d: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     i, got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
   endtask

   task automatic test_mid_reset();
      int e0;
      logic [7:0] ab;
      ab = 8'h5A;
      got_q.delete(); exp_q.delete();
      @(negedge clk);
      data_input = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         repeat (CPB) @(negedge clk);
         data_input = ab[i];
      end
      repeat (HALF) @(negedge clk);
      rst_n = 1'b0;
      data_input = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({data_out, data_valid, frame_err, parity_err, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_state: got dout=%h vld=%b ferr=%b perr=%b busy=%b, expected all 0",
                  data_out, data_valid, frame_err, parity_err, busy);
      end
      rst_n = 1'b1;
      idle(30);
      checks++;
      if (got_q.size() !== 0) begin
         errors++;
         $display("FAIL midreset_abort: got %0d pulses, expected 0", got_q.size());
      end
      send_frame(8'h81, 1'b1, 1'b0, e0);
      idle(20);
      exp_q.push_back('{vcyc(e0), 8'h81, 1'b0, eperr(8'h81, 1'b0)});
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL midreset_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL midreset_pulse: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
   endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
   task automatic test_parity();
      int e0, e1;
      got_q.delete(); exp_q.delete();
      send_frame(8'h07, 1'b1, 1'b1, e0);
      idle(5);
      send_frame(8'h07, 1'b1, 1'b0, e1);
      idle(20);
      exp_q.push_back('{vcyc(e0), 8'h07, 1'b0, 1'b0});
      exp_q.push_back('{vcyc(e1), 8'h07, 1'b0, 1'b1});
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL parity_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL parity_pulse%0d: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     i, got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
   endtask
`endif

   task automatic test_random();
      int e0, gap;
      logic [7:0] d;
      logic stop, pbit;
      got_q.delete(); exp_q.delete();
      for (int n = 0; n < 12; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         pbit = 1'($urandom);
         gap  = stop ? $urandom_range(0, 3) : $urandom_range(2, 5);
         send_frame(d, stop, pbit, e0);
         exp_q.push_back('{vcyc(e0), d, !stop, eperr(d, pbit)});
         if (gap > 0) idle(gap);
      end
      idle(20);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL random_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i].cyc !== exp_q[i].cyc || got_q[i].d !== exp_q[i].d ||
             got_q[i].fe !== exp_q[i].fe || got_q[i].pe !== exp_q[i].pe) begin
            errors++;
            $display("FAIL random_pulse%0d: got cyc=%0d d=%h fe=%b pe=%b, expected cyc=%0d d=%h fe=%b pe=%b",
                     i, got_q[i].cyc, got_q[i].d, got_q[i].fe, got_q[i].pe,
                     exp_q[i].cyc, exp_q[i].d, exp_q[i].fe, exp_q[i].pe);
         end
      end
   endtask

   initial begin
      test_reset();
      test_a5();
      test_false_start();
      test_break();
      test_back_to_back();
      test_mid_reset();
`ifdef SERIAL_FRAME_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      checks++;
      if (qual_viol !== 0) begin
         errors++;
         $display("FAIL qualifier: got %0d cycles with an error flag but no valid, expected 0",
                  qual_viol);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
